// File: rtl/ctrl_seq_pkg.sv
// rtl/ctrl_seq_pkg.sv - opcodes, T-state indices and control-word type for the SAP controller-sequencer
package ctrl_seq_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

    localparam logic [5:0] T_RESET = 6'b000001;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_word_t;

    function automatic logic is_onehot6(input logic [5:0] v);
        return (v != 6'd0) && ((v & (v - 6'd1)) == 6'd0);
    endfunction

endpackage

// File: rtl/ctrl_seq_ring_counter.sv
// rtl/ctrl_seq_ring_counter.sv - six-state one-hot ring with hold and illegal-state recovery
module ctrl_seq_ring_counter
    import ctrl_seq_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic       hold,
    output logic [5:0] t
);

    logic [5:0] t_q;
    logic [5:0] t_d;

    // Recovery takes priority over hold so an upset can never stick while halted.
    always_comb begin
        t_d = t_q;
        if (!is_onehot6(t_q)) begin
            t_d = T_RESET;
        end else if (!hold) begin
            t_d = {t_q[4:0], t_q[5]};
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            t_q <= T_RESET;
        end else begin
            t_q <= t_d;
        end
    end

    assign t = t_q;

endmodule

// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - SAP controller-sequencer: T-state ring plus opcode x T-state control-word decode
module ctrl_seq
    import ctrl_seq_pkg::*;
(
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] ctrl,
    output logic       cp,
    output logic       ep,
    output logic       lm,
    output logic       ce,
    output logic       li,
    output logic       ei,
    output logic       la,
    output logic       ea,
    output logic       su,
    output logic       eu,
    output logic       lb,
    output logic       lo,
    output logic       hlt,
    output logic [5:0] t
);

    ctrl_word_t cw;
    ctrl_word_t cw_out;
    logic       hlt_q;
    logic       halt_now;

    // The HLT edge must freeze the ring in the same cycle the flag is set.
    assign halt_now = t[T4_IDX] && (ctrl == OP_HLT);

    ctrl_seq_ring_counter u_ring_counter (
        .clk  (clk),
        .clr  (clr),
        .hold (hlt_q | halt_now),
        .t    (t)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            hlt_q <= 1'b0;
        end else if (halt_now) begin
            hlt_q <= 1'b1;
        end
    end

    always_comb begin
        cw = '0;
        if (t[T1_IDX]) begin
            cw.ep = 1'b1;
            cw.lm = 1'b1;
        end
        if (t[T2_IDX]) begin
            cw.cp = 1'b1;
        end
        if (t[T3_IDX]) begin
            cw.ce = 1'b1;
            cw.li = 1'b1;
        end
        case (ctrl)
            OP_LDA: begin
                if (t[T4_IDX]) begin cw.ei = 1'b1; cw.lm = 1'b1; end
                if (t[T5_IDX]) begin cw.ce = 1'b1; cw.la = 1'b1; end
            end
            OP_ADD, OP_SUB: begin
                if (t[T4_IDX]) begin cw.ei = 1'b1; cw.lm = 1'b1; end
                if (t[T5_IDX]) begin cw.ce = 1'b1; cw.lb = 1'b1; end
                if (t[T6_IDX]) begin
                    cw.la = 1'b1;
                    cw.eu = 1'b1;
                    cw.su = (ctrl == OP_SUB);
                end
            end
            OP_OUT: begin
                if (t[T4_IDX]) begin cw.ea = 1'b1; cw.lo = 1'b1; end
            end
            default: ;
        endcase
    end

    assign cw_out = hlt_q ? '0 : cw;
    assign {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = cw_out;
    assign hlt = hlt_q;

    a_one_bus_driver: assert property (
        @(posedge clk) disable iff (!clr) $countones({ep, ce, ei, ea, eu}) <= 1
    );

endmodule

// File: tb/tb_ctrl_seq.sv
// tb/tb_ctrl_seq.sv - directed self-checking bench for ctrl_seq
module tb_ctrl_seq;

    logic       clk;
    logic       clr;
    logic [3:0] ctrl;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic [5:0] t;

    int nvec;
    int nerr;

    ctrl_seq dut (
        .clk  (clk),
        .clr  (clr),
        .ctrl (ctrl),
        .cp   (cp),
        .ep   (ep),
        .lm   (lm),
        .ce   (ce),
        .li   (li),
        .ei   (ei),
        .la   (la),
        .ea   (ea),
        .su   (su),
        .eu   (eu),
        .lb   (lb),
        .lo   (lo),
        .hlt  (hlt),
        .t    (t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}
    function automatic logic [11:0] word_now();
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo};
    endfunction

    function automatic int drivers_now();
        return int'(ep) + int'(ce) + int'(ei) + int'(ea) + int'(eu);
    endfunction

    task automatic test_reset();
        clr  = 1'b1;
        ctrl = 4'h0;
        #3 clr = 1'b0;
        #1;
        nvec++;
        if (t !== 6'b000001) begin nerr++; $display("FAIL reset_t: got %b expected %b", t, 6'b000001); end
        nvec++;
        if (hlt !== 1'b0) begin nerr++; $display("FAIL reset_hlt: got %b expected 0", hlt); end
        nvec++;
        if (word_now() !== 12'h600) begin nerr++; $display("FAIL reset_word: got %h expected %h", word_now(), 12'h600); end
        @(negedge clk);
        @(negedge clk);
        nvec++;
        if (t !== 6'b000001) begin nerr++; $display("FAIL reset_held_t: got %b expected %b", t, 6'b000001); end
        clr = 1'b1;
    endtask

    task automatic test_sequence(input string name, input logic [3:0] op,
                                 input logic [11:0] w4, input logic [11:0] w5, input logic [11:0] w6);
        logic [11:0] exp_w [6];
        exp_w = '{12'h600, 12'h800, 12'h180, w4, w5, w6};
        ctrl = op;
        for (int i = 0; i < 6; i++) begin
            nvec++;
            if (word_now() !== exp_w[i]) begin
                nerr++; $display("FAIL %s_word_T%0d: got %h expected %h", name, i + 1, word_now(), exp_w[i]);
            end
            nvec++;
            if (t !== (6'b000001 << i)) begin
                nerr++; $display("FAIL %s_t_T%0d: got %b expected %b", name, i + 1, t, 6'b000001 << i);
            end
            nvec++;
            if (drivers_now() > 1) begin
                nerr++; $display("FAIL %s_bus_T%0d: got %0d drivers expected at most 1", name, i + 1, drivers_now());
            end
            @(negedge clk);
        end
        nvec++;
        if (t !== 6'b000001 || hlt !== 1'b0) begin
            nerr++; $display("FAIL %s_wrap: got t=%b hlt=%b expected t=000001 hlt=0", name, t, hlt);
        end
    endtask

    task automatic test_lda();
        test_sequence("lda", 4'b0000, 12'h240, 12'h120, 12'h000);
    endtask

    task automatic test_add_sub();
        test_sequence("add", 4'b0001, 12'h240, 12'h102, 12'h024);
        test_sequence("sub", 4'b0010, 12'h240, 12'h102, 12'h02C);
    endtask

    task automatic test_out();
        test_sequence("out", 4'b1110, 12'h011, 12'h000, 12'h000);
    endtask

    task automatic test_undefined();
        test_sequence("nop", 4'b0101, 12'h000, 12'h000, 12'h000);
    endtask

    task automatic test_reset_mid();
        ctrl = 4'b0001;
        repeat (4) @(negedge clk);
        nvec++;
        if (t !== 6'b010000) begin nerr++; $display("FAIL mid_pre_t: got %b expected %b", t, 6'b010000); end
        #2 clr = 1'b0;
        #1;
        nvec++;
        if (t !== 6'b000001) begin nerr++; $display("FAIL mid_async_t: got %b expected %b", t, 6'b000001); end
        nvec++;
        if (hlt !== 1'b0) begin nerr++; $display("FAIL mid_async_hlt: got %b expected 0", hlt); end
        nvec++;
        if (word_now() !== 12'h600) begin nerr++; $display("FAIL mid_async_word: got %h expected %h", word_now(), 12'h600); end
        @(posedge clk);
        #1;
        nvec++;
        if (t !== 6'b000001) begin nerr++; $display("FAIL mid_hold_t: got %b expected %b", t, 6'b000001); end
        @(negedge clk);
        clr = 1'b1;
        test_sequence("mid_add", 4'b0001, 12'h240, 12'h102, 12'h024);
    endtask

    task automatic test_hlt();
        logic [3:0] toggles [4];
        toggles = '{4'b0000, 4'b1110, 4'b0010, 4'b1111};
        ctrl = 4'b1111;
        repeat (3) @(negedge clk);
        nvec++;
        if (word_now() !== 12'h000 || t !== 6'b001000 || hlt !== 1'b0) begin
            nerr++; $display("FAIL hlt_T4: got word=%h t=%b hlt=%b expected word=000 t=001000 hlt=0", word_now(), t, hlt);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            nvec++;
            if (hlt !== 1'b1 || t !== 6'b001000 || word_now() !== 12'h000) begin
                nerr++; $display("FAIL hlt_hold_%0d: got hlt=%b t=%b word=%h expected hlt=1 t=001000 word=000", i, hlt, t, word_now());
            end
            ctrl = toggles[i % 4];
        end
        #2 clr = 1'b0;
        #1;
        nvec++;
        if (t !== 6'b000001 || hlt !== 1'b0 || word_now() !== 12'h600) begin
            nerr++; $display("FAIL hlt_exit: got t=%b hlt=%b word=%h expected t=000001 hlt=0 word=600", t, hlt, word_now());
        end
        @(negedge clk);
        clr = 1'b1;
        test_sequence("post_hlt", 4'b0000, 12'h240, 12'h120, 12'h000);
    endtask

    task automatic test_illegal();
        ctrl = 4'b0101;
        force dut.u_ring_counter.t_q = 6'b000011;
        #1;
        nvec++;
        if (t !== 6'b000011) begin nerr++; $display("FAIL illegal_forced_t: got %b expected %b", t, 6'b000011); end
        release dut.u_ring_counter.t_q;
        @(negedge clk);
        nvec++;
        if (t !== 6'b000001) begin nerr++; $display("FAIL illegal_recover_t: got %b expected %b", t, 6'b000001); end
        test_sequence("after_upset", 4'b0101, 12'h000, 12'h000, 12'h000);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;
        clr  = 1'b1;
        ctrl = 4'h0;
        test_reset();
        test_lda();
        test_add_sub();
        test_out();
        test_undefined();
        test_reset_mid();
        test_hlt();
        test_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ctrl_seq.md
Name: ctrl_seq

Overview:
- Controller-sequencer for the 8-bit SAP-style CPU; consumer of the opcode nibble the instruction register drives on its ctrl output.
- Runs a six-state ring counter (T1..T6) and decodes opcode × T-state into the control word.
- The control word drives PC, MAR, RAM, IR, accumulator, ALU, B and output registers, including the IR's own li/ei strobes.
- Implements fetch (T1-T3), execute (T4-T6) and halt.

Parameters:
- OP_LDA, 4'b0000, load accumulator opcode
- OP_ADD, 4'b0001, add opcode
- OP_SUB, 4'b0010, subtract opcode
- OP_OUT, 4'b1110, output opcode
- OP_HLT, 4'b1111, halt opcode

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-low
- ctrl  in  4  opcode nibble from the instruction register
- cp  out  1  PC increment
- ep  out  1  PC enable to bus
- lm  out  1  MAR load
- ce  out  1  RAM enable to bus
- li  out  1  IR load
- ei  out  1  IR operand enable to bus
- la  out  1  accumulator load
- ea  out  1  accumulator enable to bus
- su  out  1  ALU subtract select
- eu  out  1  ALU enable to bus
- lb  out  1  B register load
- lo  out  1  output register load
- hlt  out  1  halted flag
- t  out  6  one-hot T-state, bit0 = T1

Behaviour:
- State is a 6-bit one-hot ring t plus a halt flag.
  - clr=0 forces t=6'b000001 and hlt=0 immediately, without waiting for clk.
  - Both values are held while clr=0.
- Ring advances T1→T2→…→T6→T1, one step per clk edge, while hlt=0.
- Control outputs are combinational from t, ctrl and hlt. There is no added latency; signals are valid for the whole T-state.
- Fetch (opcode-independent):
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- ctrl is ignored in T1-T3. The IR captures at the T3→T4 edge, so ctrl is valid and stable in T4-T6.
- Execute:
  - LDA: T4 ei, lm; T5 ce, la; T6 none
  - ADD: T4 ei, lm; T5 ce, lb; T6 la, eu (su=0)
  - SUB: same as ADD, with su=1 during T6 only
  - OUT: T4 ea, lo; T5 none; T6 none
  - HLT: T4 none. At the edge ending T4, hlt←1 and t holds at T4 (6'b001000).
  - Any other opcode: T4-T6 none (NOP), then wrap to T1.
- While hlt=1:
  - All twelve control outputs are 0.
  - t is frozen and ctrl is ignored.
  - Only clr exits the halt.
- Under reset the T1 decode applies, so ep=lm=1 and all other control outputs are 0. The PC is cleared concurrently by the same clr.
- Reset mid-instruction: the partial instruction is abandoned and fetch restarts at T1 on the first edge after clr deasserts. No stale halt is kept.
- At most one bus driver (ep, ce, ei, ea, eu) is asserted in any state. This is a checked invariant.
- The ring must never hold a non-one-hot value. If it does (e.g. an upset), the next edge loads T1.

Decomposition:
- Shared package holds:
  - the opcode constants above
  - T-state index constants T1_IDX..T6_IDX
  - a packed control-word type with field order cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
- One natural sub-module, ring_counter: 6-bit one-hot, with async active-low clr, a hold input (driven by hlt) and illegal-state recovery.
- Decode stays in ctrl_seq.

Test Plan:
1. Reset mid-run: assert clr=0 during T5 of ADD → t=000001, hlt=0, ep=lm=1 and all others 0 without a clk edge. After release, T1..T3 sequence normally.
2. LDA (ctrl=0000) → per cycle:
   - T1 {ep,lm}
   - T2 {cp}
   - T3 {ce,li}
   - T4 {ei,lm}
   - T5 {ce,la}
   - T6 {}
   - then t=000001 again
3. ADD then SUB (ctrl=0001, then 0010):
   - T5 {ce,lb} for both
   - T6 {la,eu}: su=0 for ADD, su=1 for SUB
   - su=0 in every other state
4. OUT (ctrl=1110) → T4 {ea,lo}; T5 and T6 all 0; wraps to T1.
5. HLT (ctrl=1111):
   - T4 all 0
   - after the edge, hlt=1 and t=001000, held with all outputs 0 for 10+ cycles while ctrl toggles
   - clr pulse → t=000001, hlt=0
6. Undefined opcode 0101 → T4-T6 all 0, then wraps to T1. Also force t=000011 via a bench hook → next edge t=000001. The single-bus-driver assertion never fires across all scenarios.
